// File: rtl/jmp_hazard_ctrl_if.sv
// Handshake bundle between the decode-stage control unit and the JMP/CALL
// sequencing controller: jump request, hazard sources, stack push handshake
// and the resulting pipeline steering signals.
interface jmp_hazard_ctrl_if;
  logic       jmp_group;
  logic       brx;
  logic [2:0] rb_id;
  logic       we_ex;
  logic [2:0] dest_ex;
  logic       we_mem;
  logic [2:0] dest_mem;
  logic       we_wb;
  logic [2:0] dest_wb;
  logic       hold;
  logic       push_ack;
  logic       stall_fd;
  logic       bubble_ex;
  logic       pc_load;
  logic       flush_if;
  logic       push_req;
  logic       busy;

  // Pipeline side: drives the request and hazard sources, receives steering.
  modport master (
    output jmp_group, brx, rb_id, we_ex, dest_ex, we_mem, dest_mem,
           we_wb, dest_wb, hold, push_ack,
    input  stall_fd, bubble_ex, pc_load, flush_if, push_req, busy
  );

  // Controller side.
  modport slave (
    input  jmp_group, brx, rb_id, we_ex, dest_ex, we_mem, dest_mem,
           we_wb, dest_wb, hold, push_ack,
    output stall_fd, bubble_ex, pc_load, flush_if, push_req, busy
  );
endinterface

// File: rtl/jmp_hazard_ctrl.sv
// JMP/CALL sequencing controller for the decode stage. Stalls fetch/decode
// for as many cycles as the nearest in-flight producer of the jump-target
// register needs, runs the CALL return-address push handshake, then issues
// a one-cycle PC load with an IF/ID flush. Outputs are Mealy.
module jmp_hazard_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  jmp_hazard_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_PUSH    = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] depth;

  logic stall_fd_c, bubble_ex_c, pc_load_c, flush_if_c, push_req_c;

  // Hazard depth on rb: the nearest stage holding a pending write wins.
  always_comb begin
    if (bus.we_ex && bus.dest_ex == bus.rb_id)
      depth = 2'd3;
    else if (bus.we_mem && bus.dest_mem == bus.rb_id)
      depth = 2'd2;
    else if (bus.we_wb && bus.dest_wb == bus.rb_id)
      depth = 2'd1;
    else
      depth = 2'd0;
  end

  // Next-state, counter and Mealy output decode.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_fd_c  = 1'b0;
    bubble_ex_c = 1'b0;
    pc_load_c   = 1'b0;
    flush_if_c  = 1'b0;
    push_req_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.jmp_group && !bus.hold) begin
          if (depth >= 2'd2) begin
            stall_fd_c  = 1'b1;
            bubble_ex_c = 1'b1;
            cnt_d       = depth - 2'd1;
            state_d     = ST_WAIT;
          end else if (depth == 2'd1) begin
            stall_fd_c  = 1'b1;
            bubble_ex_c = 1'b1;
            state_d     = ST_RESOLVE;
          end else if (!bus.brx) begin
            // No hazard, JMP: redirect right away.
            pc_load_c  = 1'b1;
            flush_if_c = 1'b1;
          end else begin
            // No hazard, CALL: start the push in this same cycle.
            push_req_c  = 1'b1;
            stall_fd_c  = 1'b1;
            bubble_ex_c = 1'b1;
            if (bus.push_ack) begin
              pc_load_c  = 1'b1;
              flush_if_c = 1'b1;
            end else begin
              state_d = ST_PUSH;
            end
          end
        end
      end

      ST_WAIT: begin
        stall_fd_c  = 1'b1;
        bubble_ex_c = 1'b1;
        if (!bus.hold) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1)
            state_d = ST_RESOLVE;
        end
      end

      ST_RESOLVE: begin
        if (bus.brx) begin
          stall_fd_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end
        if (!bus.hold) begin
          if (!bus.brx) begin
            pc_load_c  = 1'b1;
            flush_if_c = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            push_req_c = 1'b1;
            if (bus.push_ack) begin
              pc_load_c  = 1'b1;
              flush_if_c = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_PUSH;
            end
          end
        end
      end

      ST_PUSH: begin
        // hold is ignored here: an ack is consumed whenever it arrives.
        push_req_c  = 1'b1;
        stall_fd_c  = 1'b1;
        bubble_ex_c = 1'b1;
        if (bus.push_ack) begin
          pc_load_c  = 1'b1;
          flush_if_c = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted.
  always_comb begin
    bus.stall_fd  = rst_n & stall_fd_c;
    bus.bubble_ex = rst_n & bubble_ex_c;
    bus.pc_load   = rst_n & pc_load_c;
    bus.flush_if  = rst_n & flush_if_c;
    bus.push_req  = rst_n & push_req_c;
    bus.busy      = rst_n & (state_q != ST_IDLE);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_jmp_hazard_ctrl.sv
// Self-checking bench for jmp_hazard_ctrl. Each cycle's stimulus carries its
// expected outputs {stall_fd, bubble_ex, pc_load, flush_if, push_req, busy};
// the expectation is queued when the stimulus is driven and compared at the
// falling edge, where the Mealy outputs have settled.
module tb_jmp_hazard_ctrl;

  logic clk;
  logic rst_n;
  jmp_hazard_ctrl_if bus ();

  jmp_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         rst_n;
    bit         jg;
    bit         brx;
    logic [2:0] rb;
    bit         wex;
    logic [2:0] dex;
    bit         wmem;
    logic [2:0] dmem;
    bit         wwb;
    logic [2:0] dwb;
    bit         hold;
    bit         ack;
    logic [5:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t mk(string name, bit rn, bit jg, bit brx,
                              logic [2:0] rb, bit wex, logic [2:0] dex,
                              bit wmem, logic [2:0] dmem, bit wwb,
                              logic [2:0] dwb, bit hold, bit ack,
                              logic [5:0] exp);
    vec_t v;
    v.name = name; v.rst_n = rn; v.jg = jg; v.brx = brx; v.rb = rb;
    v.wex = wex; v.dex = dex; v.wmem = wmem; v.dmem = dmem;
    v.wwb = wwb; v.dwb = dwb; v.hold = hold; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [5:0] act,
                       input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (stall bubble pc flush push busy)",
               name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic step(input vec_t v);
    logic [5:0] act;
    logic [5:0] exp;
    string      nm;
    rst_n        = v.rst_n;
    bus.jmp_group = v.jg;
    bus.brx      = v.brx;
    bus.rb_id    = v.rb;
    bus.we_ex    = v.wex;
    bus.dest_ex  = v.dex;
    bus.we_mem   = v.wmem;
    bus.dest_mem = v.dmem;
    bus.we_wb    = v.wwb;
    bus.dest_wb  = v.dwb;
    bus.hold     = v.hold;
    bus.push_ack = v.ack;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    @(negedge clk);
    act = {bus.stall_fd, bus.bubble_ex, bus.pc_load, bus.flush_if,
           bus.push_req, bus.busy};
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    check(nm, act, exp);
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with no request and no hazards.
  task automatic idle(input string name);
    step(mk(name, 1, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 6'b000000));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.jmp_group = 1'b0; bus.brx = 1'b0; bus.rb_id = '0;
    bus.we_ex = 1'b0; bus.dest_ex = '0; bus.we_mem = 1'b0; bus.dest_mem = '0;
    bus.we_wb = 1'b0; bus.dest_wb = '0; bus.hold = 1'b0; bus.push_ack = 1'b0;
    @(posedge clk);
    #1;

    // Single-cycle vectors, each starting and ending in IDLE.
    tbl.push_back(mk("reset_masks_jmp", 0, 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 6'b000000));
    tbl.push_back(mk("reset_masks_call", 0, 1, 1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 6'b000000));
    tbl.push_back(mk("idle_after_reset", 1, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 6'b000000));
    tbl.push_back(mk("jmp_d0", 1, 1, 0, 3'd0, 0, 3'd1, 0, 3'd2, 0, 3'd3, 0, 0, 6'b001100));
    tbl.push_back(mk("jmp_we_off", 1, 1, 0, 3'd4, 0, 3'd4, 0, 3'd4, 0, 3'd4, 0, 0, 6'b001100));
    tbl.push_back(mk("call_d0_ack", 1, 1, 1, 3'd7, 1, 3'd6, 0, 3'd0, 0, 3'd0, 0, 1, 6'b111110));
    tbl.push_back(mk("jmp_d0_hold", 1, 1, 0, 3'd1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 6'b000000));
    tbl.push_back(mk("call_d3_hold", 1, 1, 1, 3'd2, 1, 3'd2, 0, 3'd0, 0, 3'd0, 1, 1, 6'b000000));
    tbl.push_back(mk("no_jg_hazard", 1, 0, 0, 3'd3, 1, 3'd3, 1, 3'd3, 1, 3'd3, 0, 1, 6'b000000));
    foreach (tbl[i]) step(tbl[i]);

    // JMP, d=3 from EX: stall 0-2, redirect in 3, busy 1-3.
    for (int c = 0; c < 4; c++)
      step(mk($sformatf("jmp_d3_c%0d", c), 1, 1, 0, 3'd3, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0, 0,
              (c == 0) ? 6'b110000 : (c == 3) ? 6'b001101 : 6'b110001));
    idle("jmp_d3_after");

    // JMP, MEM and WB both match: MEM is nearer, d=2.
    for (int c = 0; c < 3; c++)
      step(mk($sformatf("jmp_d2_c%0d", c), 1, 1, 0, 3'd5, 0, 3'd0, 1, 3'd5, 1, 3'd5, 0, 0,
              (c == 0) ? 6'b110000 : (c == 2) ? 6'b001101 : 6'b110001));
    idle("jmp_d2_after");

    // EX and WB both match: EX wins, d=3.
    for (int c = 0; c < 4; c++)
      step(mk($sformatf("jmp_prio_c%0d", c), 1, 1, 0, 3'd6, 1, 3'd6, 0, 3'd0, 1, 3'd6, 0, 0,
              (c == 0) ? 6'b110000 : (c == 3) ? 6'b001101 : 6'b110001));
    idle("jmp_prio_after");

    // CALL, d=1 from WB, ack 2 cycles after push_req rises.
    step(mk("call_k2_c0", 1, 1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 1, 3'd2, 0, 0, 6'b110000));
    step(mk("call_k2_c1", 1, 1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 1, 3'd2, 0, 0, 6'b110011));
    step(mk("call_k2_c2", 1, 1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 1, 3'd2, 0, 0, 6'b110011));
    step(mk("call_k2_c3", 1, 1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 1, 3'd2, 0, 1, 6'b111111));
    idle("call_k2_after");

    // JMP d=3 with hold in cycles 1-2: counter frozen, redirect in cycle 5.
    for (int c = 0; c < 6; c++)
      step(mk($sformatf("jmp_hold_c%0d", c), 1, 1, 0, 3'd3, 1, 3'd3, 0, 3'd0, 0, 3'd0,
              (c == 1 || c == 2), 0,
              (c == 0) ? 6'b110000 : (c == 5) ? 6'b001101 : 6'b110001));
    idle("jmp_hold_after");

    // CALL d=0 without ack enters PUSH; ack under hold is consumed.
    step(mk("push_hold_c0", 1, 1, 1, 3'd1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 6'b110010));
    step(mk("push_hold_c1", 1, 1, 1, 3'd1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1, 6'b111111));
    idle("push_hold_after");

    // Hold in RESOLVE: CALL keeps stall/bubble, JMP shows nothing but busy.
    step(mk("call_res_hold_c0", 1, 1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 1, 3'd4, 0, 0, 6'b110000));
    step(mk("call_res_hold_c1", 1, 1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 1, 3'd4, 1, 1, 6'b110001));
    step(mk("call_res_hold_c2", 1, 1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 1, 3'd4, 0, 1, 6'b111111));
    idle("call_res_hold_after");
    step(mk("jmp_res_hold_c0", 1, 1, 0, 3'd4, 0, 3'd0, 0, 3'd0, 1, 3'd4, 0, 0, 6'b110000));
    step(mk("jmp_res_hold_c1", 1, 1, 0, 3'd4, 0, 3'd0, 0, 3'd0, 1, 3'd4, 1, 0, 6'b000001));
    step(mk("jmp_res_hold_c2", 1, 1, 0, 3'd4, 0, 3'd0, 0, 3'd0, 1, 3'd4, 0, 0, 6'b001101));
    idle("jmp_res_hold_after");

    // Reset in WAIT with cnt=1 abandons the jump.
    step(mk("rst_wait_c0", 1, 1, 0, 3'd3, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0, 0, 6'b110000));
    step(mk("rst_wait_c1", 1, 1, 0, 3'd3, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0, 0, 6'b110001));
    step(mk("rst_wait_c2", 0, 1, 0, 3'd3, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0, 0, 6'b000000));
    idle("rst_wait_c3");
    idle("rst_wait_c4");

    // Reset while in PUSH abandons the CALL.
    step(mk("rst_push_c0", 1, 1, 1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 6'b110010));
    step(mk("rst_push_c1", 0, 1, 1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 6'b000000));
    idle("rst_push_c2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jmp_hazard_ctrl.md
# jmp_hazard_ctrl

Sequencing controller for JMP/CALL in the decode stage. It detects read-after-write hazards on the jump-target register `rb` against the EX, MEM and WB stages, and stalls fetch/decode for exactly the required number of cycles while inserting bubbles into ID/EX. For CALL, it runs a return-address push handshake before redirecting. It then issues a one-cycle PC load with an IF/ID flush.

## Interface
Parameters:
- none. Register index width is fixed at 3; stall counter width is fixed at 2.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- jmp_group  in  1  CU flag: the instruction in ID is JMP or CALL.
- brx  in  1  0 = JMP, 1 = CALL; meaningful only while jmp_group=1.
- rb_id  in  3  jump-target register of the instruction in ID.
- we_ex, dest_ex  in  1, 3  write enable and destination register of the instruction in EX.
- we_mem, dest_mem  in  1, 3  write enable and destination register in MEM.
- we_wb, dest_wb  in  1, 3  write enable and destination register in WB.
- hold  in  1  global pipeline freeze (memory stall).
- push_ack  in  1  stack unit has accepted the return-address push.
- stall_fd  out  1  hold PC and IF/ID.
- bubble_ex  out  1  inject a NOP into ID/EX.
- pc_load  out  1  load PC from the jump target this cycle.
- flush_if  out  1  squash the instruction in IF/ID.
- push_req  out  1  request a CALL return-address push.
- busy  out  1  FSM is not in IDLE.

## Operation
- Register file writes at the end of WB; a value is readable in ID the following cycle.
- Hazard depth d is computed combinationally and only in IDLE:
  - d = 3 if we_ex && dest_ex==rb_id;
  - else d = 2 if we_mem && dest_mem==rb_id;
  - else d = 1 if we_wb && dest_wb==rb_id;
  - else d = 0.
  - The nearest producer wins. r0 gets no special treatment.
- States: IDLE, WAIT, RESOLVE, PUSH. Counter `cnt` is 2 bits.
- IDLE with jmp_group=1 and hold=0:
  - d ≥ 2: stall_fd=1, bubble_ex=1, cnt←d−1, go to WAIT.
  - d = 1: stall_fd=1, bubble_ex=1, go to RESOLVE.
  - d = 0: behave as RESOLVE in this same cycle.
- WAIT: stall_fd=1, bubble_ex=1, cnt←cnt−1. When cnt==1, go to RESOLVE.
- RESOLVE, JMP (brx=0): pc_load=1, flush_if=1, go to IDLE.
- RESOLVE, CALL (brx=1): push_req=1 and stall_fd=1, bubble_ex=1.
  - push_ack=1 in the same cycle: pc_load=1, flush_if=1, go to IDLE.
  - Otherwise, go to PUSH.
- PUSH: push_req=1, stall_fd=1, bubble_ex=1. On push_ack: pc_load=1, flush_if=1, go to IDLE.
- hold=1 in IDLE, WAIT or RESOLVE:
  - no state change and cnt is frozen;
  - pc_load, flush_if and push_req are forced to 0;
  - stall_fd and bubble_ex keep their state-based values; in IDLE they are 0.
- hold is ignored in PUSH. push_req stays high until push_ack, and an ack arriving under hold is consumed.
- Bubbles inserted during WAIT guarantee that no new producer of rb enters EX. d is never re-evaluated outside IDLE.
- busy = (state != IDLE).

## Timing
- Reset (rst_n=0 at an edge): state←IDLE, cnt←0. While rst_n is low, every output is forced to 0. Reset during WAIT or PUSH abandons the sequence; no pc_load is issued.
- Outputs are Mealy (combinational from state and inputs); state and cnt are registered.
- Stall cycles before the redirect cycle equal d. The redirect cycle itself does not assert stall_fd for JMP.
  - JMP with d=3: stall in cycles 0, 1, 2; pc_load and flush_if in cycle 3.
  - d=0 JMP: pc_load in cycle 0, zero stall.
- CALL adds k extra stall cycles, where push_ack arrives k cycles after push_req first rises. k=0 means ack in the same cycle.
- pc_load and flush_if are always coincident and last exactly one cycle per jump.

## Test plan
- JMP, rb_id=3, we_ex=1, dest_ex=3 -> stall_fd/bubble_ex high cycles 0–2, pc_load+flush_if in cycle 3 only, busy high cycles 1–3.
- JMP, rb_id=5, we_mem=1, dest_mem=5 and we_wb=1, dest_wb=5 -> d=2; stall cycles 0–1, redirect in cycle 2. Separately, no hazard -> redirect in cycle 0 with stall_fd=0.
- CALL, rb_id=2, we_wb=1, dest_wb=2, push_ack delayed 2 cycles after push_req rises -> stall cycle 0; push_req cycles 1–3; pc_load in cycle 3 only.
- JMP with d=3 and hold=1 asserted in cycle 1 for 2 cycles -> cnt frozen, redirect moves to cycle 5, and pc_load is never asserted while hold=1.
- CALL in PUSH with hold=1 and push_ack=1 -> ack consumed, pc_load=1, state IDLE next cycle.
- rst_n=0 for one cycle during WAIT (cnt=1) -> all outputs 0 that cycle, IDLE afterwards, no pc_load until a new jmp_group.
